// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO family: pointer/count width helpers
// and the recognised storage-mapping hint strings.
package fifo_pkg;

    localparam string RAM_STYLE_DISTRIBUTED = "distributed";
    localparam string RAM_STYLE_BLOCK       = "block";
    localparam string RAM_STYLE_ULTRA       = "ultra";

    // Address width for a power-of-two depth (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage for stream_fifo: one write port, one read port
// with a registered (1-cycle) read. RAM_STYLE is forwarded to synthesis.
module stream_fifo_ram
    import fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 512,
    parameter int    DEPTH      = 32,
    parameter string RAM_STYLE  = RAM_STYLE_DISTRIBUTED
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    if (RAM_STYLE != RAM_STYLE_DISTRIBUTED && RAM_STYLE != RAM_STYLE_BLOCK &&
        RAM_STYLE != RAM_STYLE_ULTRA) begin : g_bad_style
        $error("stream_fifo_ram: unknown RAM_STYLE");
    end

    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents are never reset, stale entries are simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read: rd_data holds its value whenever rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Data path: RAM -> registered read stage (vld_p1) -> output register (m_*).
// Occupancy counts every beat held anywhere in that path, so capacity is DEPTH.
// Optional macro STREAM_FIFO_COUNT_EN adds the occupancy output port count.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 512,
    parameter int    DEPTH      = 32,
    parameter int    PROG_FULL  = 16,
    parameter int    PROG_EMPTY = 2,
    parameter string RAM_STYLE  = RAM_STYLE_DISTRIBUTED
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
`ifdef STREAM_FIFO_COUNT_EN
    output logic [cnt_width(DEPTH)-1:0] count,
`endif
    output logic                        prog_full,
    output logic                        prog_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and >= 4");
    end
    if (PROG_EMPTY < 0 || PROG_EMPTY >= PROG_FULL || PROG_FULL > DEPTH) begin : g_bad_prog
        $error("stream_fifo: need 0 <= PROG_EMPTY < PROG_FULL <= DEPTH");
    end

    logic [CW-1:0]         occ;
    logic [CW-1:0]         occ_next;
    logic [CW-1:0]         ram_cnt;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  acc;
    logic                  pop;
    logic                  out_take;
    logic                  move_p1;
    logic                  rd_en;

    assign acc      = s_valid & s_ready;
    assign pop      = m_valid & m_ready;
    // Output register can load when it is empty or being drained this cycle.
    assign out_take = ~m_valid | m_ready;
    assign move_p1  = vld_p1 & out_take;
    // Fetch from RAM whenever it holds a beat and the read stage is free or advancing.
    assign rd_en    = (ram_cnt != '0) & (~vld_p1 | move_p1);

    // Next occupancy: simultaneous accept and pop cancel out.
    always_comb begin
        occ_next = occ;
        if (acc && !pop) begin
            occ_next = occ + CW'(1);
        end else if (!acc && pop) begin
            occ_next = occ - CW'(1);
        end
    end

    // Occupancy and the flags derived from it, all registered from occ_next.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= '0;
            s_ready    <= 1'b0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
        end else begin
            occ        <= occ_next;
            s_ready    <= (occ_next < CW'(DEPTH));
            prog_full  <= (occ_next >= CW'(PROG_FULL));
            prog_empty <= (occ_next <= CW'(PROG_EMPTY));
        end
    end

    // RAM pointers (wrap naturally at the power-of-two depth) and RAM-resident beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
        end else begin
            if (acc) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + PW'(1);
            end
            case ({acc, rd_en})
                2'b10:   ram_cnt <= ram_cnt + CW'(1);
                2'b01:   ram_cnt <= ram_cnt - CW'(1);
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    stream_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RAM_STYLE  (RAM_STYLE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (acc),
        .wr_addr (wptr),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rptr),
        .rd_data (data_p1)
    );

    // ---- stage p1 -> output: read-stage valid and the FWFT output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (rd_en) begin
                vld_p1 <= 1'b1;
            end else if (move_p1) begin
                vld_p1 <= 1'b0;
            end
            if (out_take) begin
                m_valid <= vld_p1;
                if (vld_p1) begin
                    m_data <= data_p1;
                end
            end
        end
    end

`ifdef STREAM_FIFO_COUNT_EN
    assign count = occ;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DATA_WIDTH=8, DEPTH=4, PROG_FULL=3, PROG_EMPTY=1).
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       prog_full;
    logic       prog_empty;
`ifdef STREAM_FIFO_COUNT_EN
    logic [2:0] count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .PROG_FULL  (3),
        .PROG_EMPTY (1),
        .RAM_STYLE  ("distributed")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
`ifdef STREAM_FIFO_COUNT_EN
        .count      (count),
`endif
        .prog_full  (prog_full),
        .prog_empty (prog_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against expected values taken just after a clock edge.
    task automatic compare_out(input string tag, input int e_sr, input int e_mv, input int e_md,
                               input int e_pf, input int e_pe, input int e_cnt, input int chk_md);
        check({tag, " s_ready"}, 32'(s_ready), 32'(e_sr));
        check({tag, " m_valid"}, 32'(m_valid), 32'(e_mv));
        if (chk_md != 0) check({tag, " m_data"}, 32'(m_data), 32'(e_md));
        check({tag, " prog_full"}, 32'(prog_full), 32'(e_pf));
        check({tag, " prog_empty"}, 32'(prog_empty), 32'(e_pe));
`ifdef STREAM_FIFO_COUNT_EN
        check({tag, " count"}, 32'(count), 32'(e_cnt));
`else
        if (e_cnt > 4) check({tag, " occupancy_bound"}, 32'(e_cnt), 32'd4);
`endif
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        int r; int sv; int sd; int mr;
        int e_sr; int e_mv; int e_md; int e_pf; int e_pe; int e_cnt;
    } vec_t;
    vec_t tbl[20];

    // ---------------- behavioural reference model ----------------
    // Beats are held in order with the edge at which they were accepted.
    // The head is visible on m_valid from two edges after its acceptance.
    typedef struct { logic [7:0] d; int t; } beat_t;
    beat_t q[$];
    int    cyc = 0;
    bit    exp_sr = 1'b0;
    bit    exp_mv = 1'b0;

    task automatic cycle(input int r, input int sv, input int sd, input int mr);
        bit acc;
        bit pop;
        rst     = 1'(r);
        s_valid = 1'(sv);
        s_data  = 8'(sd);
        m_ready = 1'(mr);
        acc = (r == 0) && (sv != 0) && exp_sr;
        pop = (r == 0) && (mr != 0) && exp_mv;
        @(posedge clk);
        #1;
        cyc++;
        if (r != 0) begin
            q.delete();
            exp_sr = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{8'(sd), cyc});
            exp_sr = (q.size() < 4);
        end
        exp_mv = (q.size() > 0) && (cyc >= q[0].t + 2);
        compare_out($sformatf("model@%0d", cyc), int'(exp_sr), int'(exp_mv),
                    exp_mv ? int'(q[0].d) : 0, int'(q.size() >= 3), int'(q.size() <= 1),
                    q.size(), (exp_mv || r != 0) ? 1 : 0);
    endtask

    initial begin
        int nxt;
        // Reset, single beat 0xA5 with backpressure, then fill to full and drain.
        tbl[0]  = '{1,0,'h00,0, 0,0,'h00,0,1,0};
        tbl[1]  = '{1,0,'h00,0, 0,0,'h00,0,1,0};
        tbl[2]  = '{0,0,'h00,0, 1,0,'h00,0,1,0};
        tbl[3]  = '{0,1,'hA5,0, 1,0,'h00,0,1,1};
        tbl[4]  = '{0,0,'h00,0, 1,0,'h00,0,1,1};
        tbl[5]  = '{0,0,'h00,0, 1,1,'hA5,0,1,1};
        tbl[6]  = '{0,0,'h00,0, 1,1,'hA5,0,1,1};
        tbl[7]  = '{0,0,'h00,1, 1,0,'h00,0,1,0};
        tbl[8]  = '{0,1,'h01,0, 1,0,'h00,0,1,1};
        tbl[9]  = '{0,1,'h02,0, 1,0,'h00,0,0,2};
        tbl[10] = '{0,1,'h03,0, 1,1,'h01,1,0,3};
        tbl[11] = '{0,1,'h04,0, 0,1,'h01,1,0,4};
        tbl[12] = '{0,1,'h05,0, 0,1,'h01,1,0,4};
        tbl[13] = '{0,1,'h05,0, 0,1,'h01,1,0,4};
        tbl[14] = '{0,1,'h05,1, 1,1,'h02,1,0,3};
        tbl[15] = '{0,1,'h05,0, 0,1,'h02,1,0,4};
        tbl[16] = '{0,0,'h00,1, 1,1,'h03,1,0,3};
        tbl[17] = '{0,0,'h00,1, 1,1,'h04,0,0,2};
        tbl[18] = '{0,0,'h00,1, 1,1,'h05,0,1,1};
        tbl[19] = '{0,0,'h00,1, 1,0,'h00,0,1,0};

        for (int i = 0; i < 20; i++) begin
            rst     = 1'(tbl[i].r);
            s_valid = 1'(tbl[i].sv);
            s_data  = 8'(tbl[i].sd);
            m_ready = 1'(tbl[i].mr);
            @(posedge clk);
            #1;
            compare_out($sformatf("tbl[%0d]", i), tbl[i].e_sr, tbl[i].e_mv, tbl[i].e_md,
                        tbl[i].e_pf, tbl[i].e_pe, tbl[i].e_cnt,
                        (tbl[i].e_mv != 0 || tbl[i].r != 0) ? 1 : 0);
        end

        // Streaming 0x00..0xFF with both sides always ready: order and 1 beat/cycle.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        nxt = 0;
        for (int i = 0; i < 262; i++) begin
            if (exp_mv) begin
                check("stream_order", 32'(m_data), 32'(nxt & 'hFF));
                nxt++;
            end
            cycle(0, (i < 256) ? 1 : 0, i & 'hFF, 1);
        end
        check("stream_beats", 32'(nxt), 32'd256);

        // Reset with three beats stored discards them; a fresh beat emerges alone.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 'h70 + k, 0);
        cycle(1, 0, 0, 0);
        check("rst_mid m_valid", 32'(m_valid), 32'd0);
        check("rst_mid prog_empty", 32'(prog_empty), 32'd1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 'h3C, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("post_rst data", 32'(m_data), 32'h3C);
        cycle(0, 0, 0, 1);
        check("post_rst drained", 32'(m_valid), 32'd0);

        // Random traffic at 50% on both sides against the model.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10000; i++) begin
            cycle(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 512, beat width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, capacity in beats; power of two, >=4.
REQ-003 SHALL provide parameter PROG_FULL, default 16, prog_full threshold in beats.
REQ-004 SHALL provide parameter PROG_EMPTY, default 2, prog_empty threshold in beats.
REQ-005 SHALL provide parameter RAM_STYLE, default "distributed", storage mapping hint ("distributed"/"block"/"ultra").
REQ-006 SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 s_valid  input  1  write side beat offered.
REQ-010 s_ready  output  1  write side can accept.
REQ-011 s_data  input  DATA_WIDTH  write beat.
REQ-012 m_valid  output  1  read beat present (first-word-fall-through).
REQ-013 m_ready  input  1  read side consumes.
REQ-014 m_data  output  DATA_WIDTH  read beat.
REQ-015 prog_full  output  1  occupancy >= PROG_FULL.
REQ-016 prog_empty  output  1  occupancy <= PROG_EMPTY.
REQ-017 count  output  $clog2(DEPTH)+1  occupancy, present only with STREAM_FIFO_COUNT_EN.

Function
REQ-018 Accept = s_valid & s_ready; pop = m_valid & m_ready; occupancy = beats accepted and not popped, including the output stage; range 0..DEPTH.
REQ-019 s_ready SHALL be registered: high after an edge iff occupancy after that edge < DEPTH.
REQ-020 At full, a pop at edge N SHALL raise s_ready after edge N; no beat is ever dropped or duplicated.
REQ-021 Empty FIFO: beat accepted at edge N SHALL appear with m_valid=1 after edge N+2 (fixed latency 2).
REQ-022 With s_valid=m_ready=1 continuously and non-empty, throughput SHALL be 1 beat/cycle, order preserved.
REQ-023 While m_valid=1 and m_ready=0, m_data SHALL hold stable; m_valid SHALL not drop without a pop.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 prog_full/prog_empty SHALL be registered from next occupancy (no extra lag vs. count).
REQ-027 Parameter violation (DEPTH not power of two or <4, not 0<=PROG_EMPTY<PROG_FULL<=DEPTH) SHALL fail elaboration.

Reset
REQ-028 During rst: s_ready=0, m_valid=0, m_data=0, prog_full=0, prog_empty=1, count=0, pointers=0.
REQ-029 s_ready SHALL rise on the first edge with rst=0.
REQ-030 rst mid-operation SHALL discard all contents, including in-flight beats; RAM array need not be cleared.

Configuration
REQ-031 Macro STREAM_FIFO_COUNT_EN defined: count port present, equal to occupancy after each edge.
REQ-032 Macro undefined: count port and its logic absent; all other behaviour identical.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the clog2-derived pointer/count width functions and RAM_STYLE string constants.
REQ-034 Storage SHALL be one sub-module stream_fifo_ram (simple dual-port, 1-cycle registered read, RAM_STYLE passed through); handshake/prefetch logic in stream_fifo.

Verification (DATA_WIDTH=8, DEPTH=4, PROG_FULL=3, PROG_EMPTY=1)
REQ-035 Reset then single write 0xA5 at edge N, m_ready=0 -> m_valid=1, m_data=0xA5 after N+2; holds until m_ready.
REQ-036 m_ready=0, write 0x01..0x06 continuously -> 4 accepted, s_ready=0 after 4th, prog_full=1 after 3rd; one pop raises s_ready next edge.
REQ-037 Streaming 0x00..0xFF with s_valid=m_ready=1 -> output 0x00..0xFF in order, 1 beat/cycle after 2-cycle fill, pointers wrap repeatedly.
REQ-038 Random s_valid/m_ready at 50% for 10000 cycles -> scoreboard exact match, occupancy never exceeds 4, prog flags consistent.
REQ-039 rst asserted with 3 beats stored -> next cycle m_valid=0, prog_empty=1, count=0; post-reset write 0x3C emerges, no stale data.
REQ-040 Build with and without STREAM_FIFO_COUNT_EN -> count tracks 0..4 in first build; REQ-035..039 pass in both.
